instr_sequencer: RTL and testbench

- Instruction-issue end of the processor's control handshake. It holds a small program memory loaded by the host/testbench.
- Presents one 16-bit instruction at a time, together with `run`, to the control unit. It advances on the control unit's `done1`/`done2` completion pulses.
- Executes J-type instructions (format 2'b10) itself, as jump or halt. The control unit treats J-type as a no-op.

---
 rtl/seq_pkg.sv | 28 ++
 rtl/seq_prog_mem.sv | 23 ++
 rtl/instr_sequencer.sv | 164 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer and the control unit:
// instruction format codes, field positions and the sequencer state encoding.
package seq_pkg;

  localparam logic [1:0] FMT_R  = 2'b00;
  localparam logic [1:0] FMT_I  = 2'b01;
  localparam logic [1:0] FMT_J  = 2'b10;
  localparam logic [1:0] FMT_LS = 2'b11;

  localparam int FMT_LSB  = 0;
  localparam int FMT_MSB  = 1;
  localparam int HALT_BIT = 2;
  localparam int TGT_LSB  = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_RETIRE = 3'd3,
    ST_HALTED = 3'd4,
    ST_ERROR  = 3'd5
  } seq_state_e;

  function automatic logic [1:0] instr_fmt(input logic [15:0] ins);
    return ins[FMT_MSB:FMT_LSB];
  endfunction

endpackage

// File: rtl/seq_prog_mem.sv
// Program memory: synchronous write, combinational read, 16-bit words.
module seq_prog_mem #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);

  logic [15:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Issues program words to the control unit and executes J-type jump/halt itself.
// Optional watchdog on the issue-to-retire time is enabled by SEQ_WATCHDOG_EN.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  input  logic [ADDR_W-1:0] prog_last,
  input  logic              done1,
  input  logic              done2,
  output logic [15:0]       instruction,
  output logic              run,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              err
);

  seq_state_e        state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] last_q;
  logic [15:0]       instr_q;
  logic              run_q;
  logic              busy_q;
  logic              halted_q;

  logic              fmt_j;
  logic              is_halt;
  logic              is_jump;
  logic [ADDR_W-1:0] tgt;
  logic              retire;
  logic              stop_d;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_data;
  logic              mem_we;

  assign mem_we = prog_we && (state_q == ST_IDLE || state_q == ST_HALTED || state_q == ST_ERROR);

  seq_prog_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Single read port: FETCH reads the current pc, otherwise the successor is
  // looked up so it can be loaded on the very edge that retires.
  always_comb begin
    fmt_j   = (instr_fmt(instr_q) == FMT_J);
    is_halt = fmt_j && instr_q[HALT_BIT];
    is_jump = fmt_j && !instr_q[HALT_BIT];
    tgt     = instr_q[TGT_LSB +: ADDR_W];
    retire  = (state_q == ST_ISSUE && done1 && done2) || (state_q == ST_RETIRE && done2);
    stop_d  = is_halt || (is_jump && (tgt > last_q)) || (!fmt_j && (pc_q == last_q));
    pc_d    = is_jump ? tgt : pc_q + ADDR_W'(1);
    rd_addr = (state_q == ST_FETCH) ? pc_q : pc_d;
  end

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;
  logic            err_q;
  logic            wd_expired;

  assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));
  assign err        = err_q;
`else
  logic [31:0] timeout_unused;

  assign timeout_unused = 32'(TIMEOUT);
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      last_q   <= '0;
      instr_q  <= 16'h0000;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wd_q     <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_HALTED, ST_ERROR: begin
          if (start) begin
            pc_q     <= '0;
            last_q   <= prog_last;
            state_q  <= ST_FETCH;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            err_q    <= 1'b0;
`endif
          end
        end
        ST_FETCH: begin
          instr_q <= rd_data;
          run_q   <= 1'b1;
          state_q <= ST_ISSUE;
`ifdef SEQ_WATCHDOG_EN
          wd_q    <= '0;
`endif
        end
        ST_ISSUE, ST_RETIRE: begin
          if (retire) begin
`ifdef SEQ_WATCHDOG_EN
            wd_q <= '0;
`endif
            if (stop_d) begin
              state_q  <= ST_HALTED;
              run_q    <= 1'b0;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              // run stays high so the control unit sees an unbroken stream
              pc_q    <= pc_d;
              instr_q <= rd_data;
              state_q <= ST_ISSUE;
            end
          end
`ifdef SEQ_WATCHDOG_EN
          else if (wd_expired) begin
            state_q <= ST_ERROR;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end
`endif
          else begin
            if (state_q == ST_ISSUE && done1) begin
              state_q <= ST_RETIRE;
            end
`ifdef SEQ_WATCHDOG_EN
            wd_q <= wd_q + WD_W'(1);
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instruction = instr_q;
  assign run         = run_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized
// programs checked against a program-level reference model.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic [3:0]  prog_last = '0;
  logic        done1 = 1'b0;
  logic        done2 = 1'b0;
  logic [15:0] instruction;
  logic        run;
  logic [3:0]  pc;
  logic        busy;
  logic        halted;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic [15:0] model_mem [16];

  instr_sequencer #(.ADDR_W(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_last   (prog_last),
    .done1       (done1),
    .done2       (done2),
    .instruction (instruction),
    .run         (run),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .err         (err)
  );

  always #5 clk = ~clk;

  // All drive tasks begin and end just after a falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = 4'(a); prog_data = d;
    cyc(1);
    prog_we = 1'b0;
  endtask

  task automatic do_start(input int last);
    start = 1'b1; prog_last = 4'(last);
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse(input logic d1, input logic d2);
    done1 = d1; done2 = d2;
    cyc(1);
    done1 = 1'b0; done2 = 1'b0;
  endtask

  task automatic do_retire(input int g1, input int g2, input bit together);
    cyc(g1);
    if (together) begin
      pulse(1'b1, 1'b1);
    end else begin
      pulse(1'b1, 1'b0);
      cyc(g2);
      pulse(1'b0, 1'b1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  // Program-level rule: what happens after the instruction at cur retires.
  task automatic model_next(input logic [15:0] ins, input int cur, input int last,
                            output bit stop, output int nxt);
    nxt = cur;
    if (ins[1:0] == 2'b10) begin
      if (ins[2]) begin
        stop = 1'b1;
      end else begin
        nxt  = int'(ins[8:5]);
        stop = (nxt > last);
        if (stop) nxt = cur;
      end
    end else begin
      stop = (cur == last);
      if (!stop) nxt = cur + 1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(2);
    checks++; if (run !== 1'b0) begin failures++; $display("FAIL reset_run got=%0h exp=0", run); end
    checks++; if (pc !== 4'd0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", pc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0h exp=0", halted); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h exp=0", err); end
    checks++; if (instruction !== 16'h0000) begin failures++; $display("FAIL reset_instr got=%h exp=0000", instruction); end
    reset = 1'b0;
    $display("txn reset done");
  endtask

  task automatic test_basic();
    load(0, 16'h20A1);
    load(1, 16'h2400);
    do_start(1);
    checks++; if (run !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL basic_fetch run=%0h busy=%0h exp run=0 busy=1", run, busy); end
    cyc(1);
    checks++; if (run !== 1'b1 || instruction !== 16'h20A1 || pc !== 4'd0) begin
      failures++; $display("FAIL basic_issue0 run=%0h instr=%h pc=%0d exp 1/20A1/0", run, instruction, pc); end
    pulse(1'b1, 1'b0);
    checks++; if (run !== 1'b1 || instruction !== 16'h20A1) begin
      failures++; $display("FAIL basic_hold run=%0h instr=%h exp 1/20A1", run, instruction); end
    pulse(1'b0, 1'b1);
    checks++; if (run !== 1'b1 || instruction !== 16'h2400 || pc !== 4'd1) begin
      failures++; $display("FAIL basic_issue1 run=%0h instr=%h pc=%0d exp 1/2400/1", run, instruction, pc); end
    do_retire(1, 1, 1'b0);
    checks++; if (halted !== 1'b1 || run !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL basic_halt halted=%0h run=%0h busy=%0h exp 1/0/0", halted, run, busy); end
    $display("txn basic program done");
  endtask

  task automatic test_jump();
    load(0, 16'h0062);
    load(3, 16'h0006);
    do_start(3);
    cyc(1);
    do_retire(0, 2, 1'b0);
    checks++; if (pc !== 4'd3 || instruction !== 16'h0006 || run !== 1'b1) begin
      failures++; $display("FAIL jump_target pc=%0d instr=%h run=%0h exp 3/0006/1", pc, instruction, run); end
    do_retire(1, 0, 1'b0);
    checks++; if (halted !== 1'b1 || pc !== 4'd3 || run !== 1'b0) begin
      failures++; $display("FAIL jump_halt halted=%0h pc=%0d run=%0h exp 1/3/0", halted, pc, run); end
    $display("txn jump program done");
  endtask

  task automatic test_jump_oob();
    load(0, 16'h00A2);
    do_start(3);
    cyc(1);
    do_retire(0, 0, 1'b0);
    checks++; if (halted !== 1'b1 || pc !== 4'd0 || run !== 1'b0) begin
      failures++; $display("FAIL jump_oob halted=%0h pc=%0d run=%0h exp 1/0/0", halted, pc, run); end
    $display("txn out-of-range jump done");
  endtask

  task automatic test_write_ignored();
    load(0, 16'h20A1);
    load(1, 16'h0006);
    do_start(1);
    cyc(1);
    load(0, 16'hFFFF);
    do_retire(0, 0, 1'b1);
    checks++; if (instruction !== 16'h0006 || pc !== 4'd1) begin
      failures++; $display("FAIL wr_busy_step instr=%h pc=%0d exp 0006/1", instruction, pc); end
    do_retire(0, 0, 1'b0);
    do_start(1);
    cyc(1);
    checks++; if (instruction !== 16'h20A1 || run !== 1'b1) begin
      failures++; $display("FAIL wr_busy_ignored instr=%h run=%0h exp 20A1/1", instruction, run); end
    do_retire(0, 0, 1'b0);
    do_retire(0, 0, 1'b0);
    // write accepted in the same cycle as start must be the word fetched
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 16'h1235;
    do_start(0);
    prog_we = 1'b0;
    cyc(1);
    checks++; if (instruction !== 16'h1235) begin
      failures++; $display("FAIL wr_with_start instr=%h exp 1235", instruction); end
    do_retire(0, 0, 1'b0);
    $display("txn write protection done");
  endtask

  task automatic test_reset_mid();
    load(0, 16'h20A1);
    load(1, 16'h2400);
    load(2, 16'h0006);
    do_start(2);
    cyc(1);
    do_retire(0, 0, 1'b0);
    do_reset();
    checks++; if (run !== 1'b0 || pc !== 4'd0 || busy !== 1'b0 || instruction !== 16'h0000) begin
      failures++; $display("FAIL reset_mid run=%0h pc=%0d busy=%0h instr=%h exp 0/0/0/0000", run, pc, busy, instruction); end
    do_start(2);
    cyc(1);
    checks++; if (run !== 1'b1 || instruction !== 16'h20A1 || pc !== 4'd0) begin
      failures++; $display("FAIL reset_rerun run=%0h instr=%h pc=%0d exp 1/20A1/0", run, instruction, pc); end
    do_retire(0, 0, 1'b0);
    do_retire(0, 0, 1'b0);
    do_retire(0, 0, 1'b0);
    checks++; if (halted !== 1'b1 || pc !== 4'd2) begin
      failures++; $display("FAIL reset_rerun_end halted=%0h pc=%0d exp 1/2", halted, pc); end
    $display("txn reset mid-run done");
  endtask

  task automatic test_watchdog();
    load(0, 16'h20A1);
    do_start(0);
    cyc(1);
`ifdef SEQ_WATCHDOG_EN
    pulse(1'b1, 1'b0);
    cyc(14);
    checks++; if (err !== 1'b0 || run !== 1'b1) begin
      failures++; $display("FAIL wd_early err=%0h run=%0h exp 0/1", err, run); end
    cyc(1);
    checks++; if (err !== 1'b1 || run !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL wd_trip err=%0h run=%0h busy=%0h exp 1/0/0", err, run, busy); end
    do_start(0);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL wd_clear err=%0h exp 0", err); end
    cyc(1);
    checks++; if (run !== 1'b1 || instruction !== 16'h20A1) begin
      failures++; $display("FAIL wd_restart run=%0h instr=%h exp 1/20A1", run, instruction); end
    do_retire(0, 0, 1'b0);
`else
    pulse(1'b1, 1'b0);
    cyc(25);
    checks++; if (err !== 1'b0 || run !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL no_wd err=%0h run=%0h busy=%0h exp 0/1/1", err, run, busy); end
    pulse(1'b0, 1'b1);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL no_wd_end halted=%0h exp 1", halted); end
`endif
    $display("txn watchdog scenario done");
  endtask

  task automatic test_random();
    int last, cur, nxt, steps, kind;
    bit stop, fin;
    logic [15:0] w;
    do_reset();
    for (int t = 0; t < 30; t++) begin
      last = $urandom_range(0, 15);
      for (int a = 0; a < 16; a++) begin
        w = 16'($urandom);
        kind = $urandom_range(0, 7);
        if (kind < 1) begin
          w[2:0] = 3'b110;
        end else if (kind < 4) begin
          w[2:0] = 3'b010;
          w[8:5] = 4'($urandom_range(0, 15));
        end else if (w[1:0] == 2'b10) begin
          w[0] = 1'b1;
        end
        model_mem[a] = w;
        load(a, w);
      end
      do_start(last);
      cyc(1);
      cur = 0; steps = 0; fin = 1'b0;
      while (!fin && steps < 12) begin
        checks++; if (run !== 1'b1 || pc !== 4'(cur) || instruction !== model_mem[cur]) begin
          failures++; $display("FAIL rand_issue t=%0d step=%0d run=%0h pc=%0d instr=%h exp 1/%0d/%h",
                               t, steps, run, pc, instruction, cur, model_mem[cur]); end
        do_retire($urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        model_next(model_mem[cur], cur, last, stop, nxt);
        if (stop) begin
          checks++; if (halted !== 1'b1 || run !== 1'b0 || pc !== 4'(cur)) begin
            failures++; $display("FAIL rand_halt t=%0d halted=%0h run=%0h pc=%0d exp 1/0/%0d", t, halted, run, pc, cur); end
          fin = 1'b1;
        end
        cur = nxt;
        steps++;
      end
      if (!fin) begin
        do_reset();
      end
      $display("txn random program %0d last=%0d steps=%0d halted=%0d", t, last, steps, fin);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_jump();
    test_jump_oob();
    test_write_ignored();
    test_reset_mid();
    test_watchdog();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
